uart_receiver: RTL and testbench

//   8N1 UART receive stage; consumes the serial line driven by the TX stage (loopback or external pin).

---
 rtl/uart_receiver.sv | 147 ++++++++++++++
 tb/tb_uart_receiver.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 UART receive stage.
//   Synchronises the serial line, confirms the start bit at mid-period,
//   samples eight data bits LSB first at mid-bit, then checks the stop bit.
//   A good stop bit updates data_out and pulses rx_done. A bad stop bit
//   pulses frame_err and leaves data_out unchanged.
// Ports:
//   clk        system clock, rising edge
//   rst_n      synchronous reset, active low
//   rx_i       asynchronous serial input, idle high
//   data_out   last correctly framed byte
//   rx_done    one-cycle pulse, data_out updated
//   frame_err  one-cycle pulse, stop bit sampled low
//   rx_busy    high whenever a frame is in progress
module uart_receiver #(
    parameter int unsigned CLOCK_RATE = 100000000,
    parameter int unsigned BAUD_HEDEF = 115200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_i,
    output logic [7:0] data_out,
    output logic       rx_done,
    output logic       frame_err,
    output logic       rx_busy
);

    localparam int unsigned BAUD_DIV  = CLOCK_RATE / BAUD_HEDEF;
    localparam int unsigned HALF      = BAUD_DIV / 2;
    localparam logic [31:0] BIT_LAST  = 32'(BAUD_DIV - 1);
    localparam logic [31:0] HALF_LAST = 32'(HALF - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_e;

    state_e      state_q, state_d;
    logic        sync1_q, sync2_q;
    logic [31:0] timer_q, timer_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  data_q, data_d;
    logic        done_q, done_d;
    logic        ferr_q, ferr_d;
    logic        tick;
    logic        rx_s;

    assign rx_s = sync2_q;

    // State register plus datapath registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            timer_q   <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            done_q    <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sync1_q   <= rx_i;
            sync2_q   <= sync1_q;
            timer_q   <= timer_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            done_q    <= done_d;
            ferr_q    <= ferr_d;
        end
    end

    // Next-state logic; tick marks the terminal count of the current state.
    always_comb begin
        state_d = state_q;
        tick    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!rx_s) state_d = START;
            end
            START: begin
                if (timer_q == HALF_LAST) begin
                    tick    = 1'b1;
                    state_d = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (timer_q == BIT_LAST) begin
                    tick = 1'b1;
                    if (bit_cnt_q == 3'd7) state_d = STOP;
                end
            end
            STOP: begin
                // Leaving at mid-stop-bit lets a following start bit be
                // caught even with a single stop bit between frames.
                if (timer_q == BIT_LAST) begin
                    tick    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath next values and outputs.
    always_comb begin
        // Timer restarts at every terminal count, which covers every state
        // change as well as each data-bit boundary inside DATA.
        timer_d   = (state_q == IDLE || tick) ? '0 : timer_q + 32'd1;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        data_d    = data_q;
        done_d    = 1'b0;
        ferr_d    = 1'b0;
        unique case (state_q)
            IDLE: bit_cnt_d = '0;
            DATA: begin
                if (tick) begin
                    shift_d   = {rx_s, shift_q[7:1]};
                    // Wraps 7 -> 0 on entry to STOP.
                    bit_cnt_d = bit_cnt_q + 3'd1;
                end
            end
            STOP: begin
                if (tick) begin
                    if (rx_s) begin
                        data_d = shift_q;
                        done_d = 1'b1;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end
            end
            default: ;
        endcase
        rx_busy = (state_q != IDLE);
    end

    assign data_out  = data_q;
    assign rx_done   = done_q;
    assign frame_err = ferr_q;

endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: directed bench for uart_receiver with a scoreboard of
// expected strobes (good byte or framing error) checked by a monitor.
module tb_uart_receiver;

    localparam int BAUD = 868;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx_i;
    logic [7:0] data_out;
    logic       rx_done;
    logic       frame_err;
    logic       rx_busy;

    typedef struct {
        bit         err;
        logic [7:0] d;
    } exp_t;

    exp_t sb[$];
    int   passed = 0;
    int   total  = 0;
    int   cyc    = 0;
    int   start_cyc = 0;
    int   done_cyc  = 0;

    uart_receiver #(
        .CLOCK_RATE(100000000),
        .BAUD_HEDEF(115200)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx_i     (rx_i),
        .data_out (data_out),
        .rx_done  (rx_done),
        .frame_err(frame_err),
        .rx_busy  (rx_busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Scoreboard monitor: every strobe must match the oldest expectation.
    always @(negedge clk) begin
        if (rx_done && frame_err) check("strobes_together", 32'd1, 32'd0);
        if (rx_done || frame_err) begin
            if (rx_done) done_cyc = cyc;
            if (sb.size() == 0) begin
                check("unexpected_strobe", {30'd0, rx_done, frame_err}, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("strobe_kind", {31'd0, frame_err}, {31'd0, e.err});
                if (!e.err) check("rx_byte", {24'd0, data_out}, {24'd0, e.d});
            end
        end
    end

    // Caller must be positioned #1 after a rising edge; returns likewise.
    task automatic drive_bit(input logic b);
        rx_i = b;
        repeat (BAUD) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        start_cyc = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(stop);
        rx_i = 1'b1;
    endtask

    task automatic push(input bit err, input logic [7:0] d);
        exp_t e;
        e.err = err;
        e.d   = d;
        sb.push_back(e);
    endtask

    initial begin
        int lat;
        rst_n = 1'b0;
        rx_i  = 1'b1;
        // Reset with the line toggling.
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1 rx_i = ~rx_i;
        end
        check("rst_data_out", {24'd0, data_out}, 32'h00);
        check("rst_rx_done", {31'd0, rx_done}, 32'd0);
        check("rst_frame_err", {31'd0, frame_err}, 32'd0);
        check("rst_rx_busy", {31'd0, rx_busy}, 32'd0);
        rx_i  = 1'b1;
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;

        // Single frame and latency.
        push(1'b0, 8'hA5);
        send_frame(8'hA5, 1'b1);
        repeat (20) @(posedge clk);
        #1;
        lat = done_cyc - start_cyc;
        check("latency_in_window", {31'd0, (lat >= 8246 && lat <= 8250)}, 32'd1);
        check("single_data_out", {24'd0, data_out}, 32'hA5);
        check("single_idle", {31'd0, rx_busy}, 32'd0);

        // Back-to-back frames, single stop bit, no gap.
        push(1'b0, 8'h00);
        push(1'b0, 8'hFF);
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        repeat (20) @(posedge clk);
        #1;
        check("b2b_data_out", {24'd0, data_out}, 32'hFF);

        // Glitch: 100 cycles low then high; START gives up at mid-bit.
        rx_i = 1'b0;
        repeat (100) @(posedge clk);
        #1 rx_i = 1'b1;
        repeat (335) @(posedge clk);
        #1 check("glitch_busy_before", {31'd0, rx_busy}, 32'd1);
        repeat (3) @(posedge clk);
        #1 check("glitch_busy_after", {31'd0, rx_busy}, 32'd0);
        repeat (200) @(posedge clk);
        #1;

        // Framing error: stop bit forced low.
        push(1'b1, 8'h00);
        send_frame(8'h3C, 1'b0);
        repeat (1000) @(posedge clk);
        #1;
        check("ferr_data_kept", {24'd0, data_out}, 32'hFF);
        check("ferr_idle", {31'd0, rx_busy}, 32'd0);

        // Reset during bit 4 of 0x81, then a clean 0x5A.
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        drive_bit(1'b0);
        drive_bit(1'b0);
        rx_i = 1'b0;
        repeat (BAUD / 2) @(posedge clk);
        #1 rst_n = 1'b0;
        rx_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("midrst_busy", {31'd0, rx_busy}, 32'd0);
        check("midrst_data_out", {24'd0, data_out}, 32'h00);
        rst_n = 1'b1;
        repeat (2000) @(posedge clk);
        #1;
        push(1'b0, 8'h5A);
        send_frame(8'h5A, 1'b1);
        repeat (20) @(posedge clk);
        #1;
        check("final_data_out", {24'd0, data_out}, 32'h5A);
        check("scoreboard_drained", sb.size(), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
